// File: rtl/systolic_operand_feeder_if.sv
// Operand-feeder bus: upstream tile-buffer handshake plus the array-edge
// outputs (skewed operands, capture strobe, status).
// master = tile-buffer / controller side, slave = feeder side.
interface systolic_operand_feeder_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    logic                 start;
    logic [CNT_W-1:0]     k_len;
    logic                 in_valid;
    logic                 in_ready;
    logic [N*WIDTH-1:0]   in_a;
    logic [N*WIDTH-1:0]   in_b;
    logic [N*WIDTH-1:0]   a_out;
    logic [N*WIDTH-1:0]   b_out;
    logic                 control;
    logic                 busy;
    logic                 done;

    modport master (
        output start, k_len, in_valid, in_a, in_b,
        input  in_ready, a_out, b_out, control, busy, done
    );

    modport slave (
        input  start, k_len, in_valid, in_a, in_b,
        output in_ready, a_out, b_out, control, busy, done
    );
endinterface

// File: rtl/systolic_operand_feeder.sv
// Systolic operand feeder: accepts one beat (N a-values + N b-values) per
// cycle, skews lane i by i+1 cycles onto the array edges, drains 2*N-1
// cycles of zeros, then issues the capture strobe and a done pulse.
// Optional build macro FEEDER_STALL_CNT_EN adds a 16-bit stall_cnt output
// counting FEED cycles without a valid beat.
module systolic_operand_feeder #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rstn,
    systolic_operand_feeder_if.slave bus
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);
    localparam int DW = $clog2(2 * N);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(2 * N - 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FEED  = 3'd1,
        S_DRAIN = 3'd2,
        S_CTRL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_k_len;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   w_beat_inc;
    logic [DW-1:0]      r_drain_cnt;
    logic               r_in_ready;
    logic               r_control;
    logic               r_busy;
    logic               r_done;
    logic               w_accept;
    logic               w_start_ok;
    logic [N*WIDTH-1:0] w_inj_a;
    logic [N*WIDTH-1:0] w_inj_b;

    // in_ready is high exactly in FEED, so this is "beat taken in FEED".
    assign w_accept   = r_in_ready & bus.in_valid;
    assign w_start_ok = (r_state == S_IDLE) & bus.start & (bus.k_len != '0);
    assign w_beat_inc = r_beat_cnt + CNT_W'(1);
    // Anything but an accepted beat injects zeros (bubbles, drain, idle).
    assign w_inj_a    = w_accept ? bus.in_a : '0;
    assign w_inj_b    = w_accept ? bus.in_b : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_state_nxt = S_FEED;
                else            w_state_nxt = S_IDLE;
            end
            S_FEED: begin
                if (w_accept && (w_beat_inc == r_k_len)) w_state_nxt = S_DRAIN;
                else                                     w_state_nxt = S_FEED;
            end
            S_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) w_state_nxt = S_CTRL;
                else                           w_state_nxt = S_DRAIN;
            end
            S_CTRL:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Tile length latch, beat counter and drain counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_k_len     <= '0;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (w_start_ok) begin
                r_k_len    <= bus.k_len;
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= w_beat_inc;
            end
            // Held at zero outside DRAIN so it starts from 0 on entry.
            if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + DW'(1);
            else                    r_drain_cnt <= '0;
        end
    end

    // Status/strobe outputs registered from the upcoming state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_control  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt == S_FEED);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_control  <= (w_state_nxt == S_CTRL);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.busy     = r_busy;
    assign bus.control  = r_control;
    assign bus.done     = r_done;

    // Per-lane skew chains: lane i has i+1 register stages, the last one
    // being the output register itself.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [WIDTH-1:0] r_dly_a [0:gi];
        logic [WIDTH-1:0] r_dly_b [0:gi];

        // Shift the lane-gi chain every cycle.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                for (int k = 0; k <= gi; k++) begin
                    r_dly_a[k] <= '0;
                    r_dly_b[k] <= '0;
                end
            end else begin
                r_dly_a[0] <= w_inj_a[gi*WIDTH +: WIDTH];
                r_dly_b[0] <= w_inj_b[gi*WIDTH +: WIDTH];
                for (int k = 1; k <= gi; k++) begin
                    r_dly_a[k] <= r_dly_a[k-1];
                    r_dly_b[k] <= r_dly_b[k-1];
                end
            end
        end

        assign bus.a_out[gi*WIDTH +: WIDTH] = r_dly_a[gi];
        assign bus.b_out[gi*WIDTH +: WIDTH] = r_dly_b[gi];
    end

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Count bubble cycles in FEED; saturating, held until the next start.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stall_cnt <= 16'h0000;
        end else if (w_start_ok) begin
            r_stall_cnt <= 16'h0000;
        end else if ((r_state == S_FEED) && !bus.in_valid &&
                     (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Self-checking bench for systolic_operand_feeder (N=4, WIDTH=8).
// Expected lane values, control and done cycles are queued when beats are
// driven and compared by a negedge monitor on the cycle they are due.
module tb_systolic_operand_feeder;
    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int CNT_W = 8;

    typedef struct {
        int               due;
        int               lane;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } sb_t;

    logic clk;
    logic rstn;
    int   cyc;
    int   n_checks;
    int   n_errors;
    bit   mon_en;

    sb_t  sb_q[$];
    sb_t  m_keep[$];
    int   q_ctrl[$];
    int   q_done[$];
    logic [N*WIDTH-1:0] m_ea;
    logic [N*WIDTH-1:0] m_eb;
    logic m_ec;
    logic m_ed;

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    systolic_operand_feeder_if #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W)) bus ();

    systolic_operand_feeder #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef FEEDER_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    // Cycle index used to time scoreboard entries.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] act,
                             input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic drive_beat(input int beat);
        for (int i = 0; i < N; i++) begin
            bus.in_a[i*WIDTH +: WIDTH] = WIDTH'(beat + i + 1);
            bus.in_b[i*WIDTH +: WIDTH] = WIDTH'(8'h50 + 16 * i + beat);
        end
    endtask

    task automatic push_beat(input int beat, input int p);
        sb_t e;
        for (int i = 0; i < N; i++) begin
            e.due  = p + i;
            e.lane = i;
            e.a    = WIDTH'(beat + i + 1);
            e.b    = WIDTH'(8'h50 + 16 * i + beat);
            sb_q.push_back(e);
        end
    endtask

    // One full tile: start, feed using valid pattern (1 after pattern ends),
    // optionally poke start during DRAIN, wait for done.
    task automatic run_tile(input int k, input logic [15:0] vpat, input int plen,
                            input bit start_in_drain, input int stalls_exp);
        int acc;
        int fc;
        int p;
        int p_last;
        logic v;
        acc = 0; fc = 0; p_last = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.k_len = CNT_W'(k);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.k_len = '0;
        check_val("busy_start", bus.busy, 1);
        check_val("ready_feed", bus.in_ready, 1);
        while (acc < k && fc < 200) begin
            v = (fc < plen) ? vpat[fc] : 1'b1;
            bus.in_valid = v;
            if (v) drive_beat(acc);
            else begin
                bus.in_a = {N{8'hEE}};
                bus.in_b = {N{8'hEE}};
            end
            @(posedge clk); #1;
            p = cyc;
            if (v) begin
                push_beat(acc, p);
                acc++;
                p_last = p;
            end else begin
                check_val("ready_bubble", bus.in_ready, 1);
            end
            fc++;
        end
        bus.in_valid = 1'b0;
        check_val("ready_drop", bus.in_ready, 0);
        q_ctrl.push_back(p_last + 2 * N - 1);
        q_done.push_back(p_last + 2 * N);
        if (start_in_drain) begin
            bus.start = 1'b1; bus.k_len = CNT_W'(5);
            @(posedge clk); #1;
            bus.start = 1'b0; bus.k_len = '0;
            check_val("busy_drain", bus.busy, 1);
        end
        for (int w = 0; w < 64 && q_done.size() != 0; w++) @(posedge clk);
        check_val("done_seen", q_done.size(), 0);
        @(posedge clk); #1;
        check_val("busy_idle", bus.busy, 0);
`ifdef FEEDER_STALL_CNT_EN
        check_val("stall_cnt", stall_cnt, stalls_exp);
`else
        if (stalls_exp < 0) $display("note: stall count %0d", stalls_exp);
`endif
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: compare edge outputs and strobes with what is due this cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            m_ea = '0;
            m_eb = '0;
            m_keep.delete();
            foreach (sb_q[k]) begin
                if (sb_q[k].due == cyc) begin
                    m_ea[sb_q[k].lane*WIDTH +: WIDTH] = sb_q[k].a;
                    m_eb[sb_q[k].lane*WIDTH +: WIDTH] = sb_q[k].b;
                end else begin
                    m_keep.push_back(sb_q[k]);
                end
            end
            sb_q = m_keep;
            m_ec = (q_ctrl.size() > 0) && (q_ctrl[0] == cyc);
            if (m_ec) void'(q_ctrl.pop_front());
            m_ed = (q_done.size() > 0) && (q_done[0] == cyc);
            if (m_ed) void'(q_done.pop_front());
            check_val("a_out", bus.a_out, m_ea);
            check_val("b_out", bus.b_out, m_eb);
            check_val("control", bus.control, m_ec);
            check_val("done", bus.done, m_ed);
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_en   = 1'b0;
        rstn     = 1'b0;
        bus.start    = 1'b1;
        bus.k_len    = CNT_W'(3);
        bus.in_valid = 1'b1;
        bus.in_a     = {N{8'hA5}};
        bus.in_b     = {N{8'h5A}};

        // Reset with start and in_valid held high.
        repeat (3) begin
            @(posedge clk); #1;
            mon_en = 1'b1;
            check_val("rst_ready", bus.in_ready, 0);
            check_val("rst_busy", bus.busy, 0);
        end
        rstn = 1'b1;
        bus.start = 1'b0; bus.k_len = '0; bus.in_valid = 1'b0;
        bus.in_a = '0; bus.in_b = '0;
        @(posedge clk); #1;
        check_val("idle_busy", bus.busy, 0);
`ifdef FEEDER_STALL_CNT_EN
        check_val("stall_rst", stall_cnt, 0);
`endif

        // Continuous tile, k_len=3.
        run_tile(3, 16'h0000, 0, 1'b0, 0);
        // Bubbles: valid 1,0,0,1 with k_len=2.
        run_tile(2, 16'b1001, 4, 1'b0, 2);

        // k_len=0 start is ignored.
        bus.start = 1'b1; bus.k_len = '0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin
            check_val("klen0_busy", bus.busy, 0);
            @(posedge clk); #1;
        end

        // start during DRAIN is ignored.
        run_tile(3, 16'h0000, 0, 1'b1, 0);

        // Reset during FEED after 1 of 5 beats.
        bus.start = 1'b1; bus.k_len = CNT_W'(5);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.k_len = '0;
        bus.in_valid = 1'b1;
        drive_beat(0);
        @(posedge clk); #1;
        push_beat(0, cyc);
        bus.in_valid = 1'b0;
        rstn = 1'b0;
        @(posedge clk); #1;
        sb_q.delete(); q_ctrl.delete(); q_done.delete();
        check_val("midrst_ready", bus.in_ready, 0);
        check_val("midrst_busy", bus.busy, 0);
        check_val("midrst_a_out", bus.a_out, 0);
`ifdef FEEDER_STALL_CNT_EN
        check_val("midrst_stall", stall_cnt, 0);
`endif
        rstn = 1'b1;
        @(posedge clk); #1;
        run_tile(1, 16'h0000, 0, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/systolic_operand_feeder.md
Name: systolic_operand_feeder

Overview:
- Transmit side of the PE operand interface: drives the west (a) and north (b) edges of an N x N systolic MAC array.
- Accepts one beat per cycle from an upstream tile buffer, where a beat is N a-values plus N b-values.
- Skews each lane by its index so operands meet diagonally inside the array.
- After the last operand has traversed the array, issues the broadcast capture strobe (control) that latches every PE's accumulator into its result register.

Parameters:
- WIDTH, 8: operand width per lane; matches the PE operand width.
- N, 4: array dimension; number of a lanes and number of b lanes.
- CNT_W, 8: width of the beat-count (k_len) field.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to begin a tile.
- k_len  input  CNT_W  number of beats in the tile; sampled when start is accepted.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  feeder accepts a beat this cycle.
- in_a  input  N*WIDTH  a operands; lane i = bits [i*WIDTH +: WIDTH].
- in_b  input  N*WIDTH  b operands; same lane mapping.
- a_out  output  N*WIDTH  skewed a to the west edge; lane i feeds row i.
- b_out  output  N*WIDTH  skewed b to the north edge; lane j feeds column j.
- control  output  1  one-cycle capture strobe to all PEs.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle tile-complete pulse.

Behaviour:
- Reset (rstn=0 at a rising edge):
  - State goes to IDLE.
  - All skew registers, a_out, b_out, the beat counter and the drain counter clear to 0.
  - in_ready, control, busy and done are 0.
  - Reset mid-tile abandons the tile; no done is issued.
- States: IDLE, FEED, DRAIN, CTRL, DONE.
- IDLE:
  - start=1 with k_len!=0: latch k_len, clear the beat counter, go to FEED.
  - start=1 with k_len==0: ignored; stay in IDLE.
- FEED:
  - in_ready=1.
  - A beat is accepted when in_valid and in_ready are both 1; the beat counter increments.
  - Cycle with in_valid=0: a bubble of all-zero operands enters every lane. Zeros contribute 0 to the PE accumulation, so no backpressure toward the array exists.
  - When the accepted count reaches the latched k_len, go to DRAIN. in_ready drops to 0 the cycle after the last acceptance.
- DRAIN:
  - in_ready=0; zeros are injected into all lanes.
  - Lasts exactly 2*N-1 cycles, timed by the drain counter; then go to CTRL.
- CTRL: control=1 for exactly one cycle; go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE.
- start while busy=1: ignored, no side effect.
- Skew:
  - Lane i of a_out and b_out equals the lane-i value injected i+1 cycles earlier: one output register plus i delay stages.
  - Lane 0 therefore has latency 1; lane N-1 has latency N.
  - a and b lanes are skewed identically.
- Skew registers shift every cycle in every non-reset state. Values left over from the previous tile drain out as zeros because DRAIN injects zeros.
- Arithmetic:
  - The beat counter is CNT_W bits and never wraps, because it stops at k_len.
  - The drain counter is sized to hold 2*N-1.

Optional Feature:
- Macro: FEEDER_STALL_CNT_EN.
- With the macro defined:
  - Extra output stall_cnt, 16 bits: number of FEED cycles with in_valid=0 in the current tile.
  - Cleared to 0 on reset and when start is accepted.
  - Saturates at 16'hFFFF.
  - Holds its value after the tile until the next accepted start.
- Without the macro: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with start=1 and in_valid=1 -> every output is 0 and state stays IDLE.
- Back-to-back tile, N=4, k_len=3, in_valid=1 every FEED cycle, in_a lanes = {4,3,2,1}+beat:
  - a_out lane 0 shows 1,2,3 on cycles 1..3 after the first acceptance.
  - Lane 3 shows 4,5,6 starting 4 cycles after the first acceptance.
  - control pulses exactly 2*N-1=7 cycles after DRAIN entry, then done pulses the next cycle.
- Bubbles: k_len=2 with in_valid pattern 1,0,0,1 -> zeros appear in the lanes for the 2 bubble cycles, DRAIN starts after the 4th FEED cycle, and stall_cnt=2 when FEEDER_STALL_CNT_EN is defined.
- k_len=0 start -> busy stays 0; no control and no done.
- start pulsed during DRAIN -> ignored; a single control and a single done are produced.
- Reset asserted during FEED after 1 of 5 beats -> all outputs 0 next cycle; a fresh start with k_len=1 completes normally with control and done.
